// File: rtl/cdb_arbiter_pkg.sv
// Shared constants and types for the CDB arbiter slice.
// Optional build macro: CDB_LSB_PRIO_EN (fixed LSB priority instead of round-robin).
package cdb_arbiter_pkg;

  localparam int ROB_W     = 4;  // width of a ROB entry tag
  localparam int CDB_DEPTH = 4;  // entries per source queue (power of 2, >= 2)
  localparam int CDB_PTR_W = 2;  // log2(CDB_DEPTH)

  typedef enum logic {
    CDB_SRC_ALU = 1'b0,
    CDB_SRC_LSB = 1'b1
  } cdb_src_e;

  typedef struct packed {
    logic [ROB_W-1:0] rob_entry;
    logic [31:0]      value;
  } cdb_entry_t;

  localparam int CDB_ENTRY_W = $bits(cdb_entry_t);

endpackage

// File: rtl/cdb_arbiter_if.sv
// Producer-side push signals, queue back-pressure and the CDB broadcast.
// slave: the arbiter. master: the producers/consumers around it.
interface cdb_arbiter_if;
  import cdb_arbiter_pkg::*;

  logic             alu_ready;
  logic [ROB_W-1:0] alu_rob_entry;
  logic [31:0]      alu_value;
  logic             lsb_ready;
  logic [ROB_W-1:0] lsb_rob_entry;
  logic [31:0]      lsb_value;
  logic             alu_afull;
  logic             lsb_afull;
  logic             cdb_valid;
  logic [ROB_W-1:0] cdb_rob_entry;
  logic [31:0]      cdb_value;
  logic             cdb_src;
  logic             cdb_overflow;

  modport slave (
    input  alu_ready, alu_rob_entry, alu_value,
    input  lsb_ready, lsb_rob_entry, lsb_value,
    output alu_afull, lsb_afull,
    output cdb_valid, cdb_rob_entry, cdb_value, cdb_src, cdb_overflow
  );

  modport master (
    output alu_ready, alu_rob_entry, alu_value,
    output lsb_ready, lsb_rob_entry, lsb_value,
    input  alu_afull, lsb_afull,
    input  cdb_valid, cdb_rob_entry, cdb_value, cdb_src, cdb_overflow
  );

endinterface

// File: rtl/cdb_arbiter_fifo.sv
// cdb_fifo: small per-source result queue. Pop frees a slot before a push
// in the same cycle, so a full queue still accepts a push when it is popped.
module cdb_fifo #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int WIDTH = 36
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             flush,
  input  logic             en,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             afull,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] FULL_C  = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] AFULL_C = (PTR_W+1)'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;
  logic             do_pop;
  logic             do_push;

  assign full    = (count == FULL_C);
  assign afull   = (count >= AFULL_C);
  assign do_pop  = en && pop && (count != '0);
  assign do_push = en && push && (!full || do_pop);

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk_in) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst_in || flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (do_push) tail_ptr <= tail_ptr + 1'b1;
      if (do_pop)  head_ptr <= head_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage write at the tail.
  always_ff @(posedge clk_in) begin
    // NOTE: storage is not reset; validity is tracked by count, so stale data is never observed.
    if (do_push) mem[tail_ptr] <= push_data;
  end

  assign head_data = mem[head_ptr];

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: drains the ALU and LSB result queues onto one registered CDB.
// Build option CDB_LSB_PRIO_EN: LSB queue always wins when nonempty;
// otherwise round-robin between the two queues, ALU winning the first tie.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
(
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         rdy_in,
  input  logic         rob_clear_up,
  cdb_arbiter_if.slave bus
);

  logic                 clear;
  logic [CDB_PTR_W:0]   alu_count;
  logic [CDB_PTR_W:0]   lsb_count;
  logic                 alu_full;
  logic                 lsb_full;
  logic                 alu_ne;
  logic                 lsb_ne;
  cdb_entry_t           alu_head;
  cdb_entry_t           lsb_head;
  logic                 grant_lsb;
  cdb_src_e             grant_src;
  logic                 alu_pop;
  logic                 lsb_pop;
  logic                 overflow_evt;

  logic                 cdb_valid_q;
  cdb_entry_t           cdb_entry_q;
  cdb_src_e             cdb_src_q;
  logic                 overflow_q;

  assign clear = rst_in || rob_clear_up;

  cdb_fifo #(.DEPTH(CDB_DEPTH), .PTR_W(CDB_PTR_W), .WIDTH(CDB_ENTRY_W)) u_alu_q (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .flush     (rob_clear_up),
    .en        (rdy_in),
    .push      (bus.alu_ready),
    .push_data ({bus.alu_rob_entry, bus.alu_value}),
    .pop       (alu_pop),
    .head_data (alu_head),
    .full      (alu_full),
    .afull     (bus.alu_afull),
    .count     (alu_count)
  );

  cdb_fifo #(.DEPTH(CDB_DEPTH), .PTR_W(CDB_PTR_W), .WIDTH(CDB_ENTRY_W)) u_lsb_q (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .flush     (rob_clear_up),
    .en        (rdy_in),
    .push      (bus.lsb_ready),
    .push_data ({bus.lsb_rob_entry, bus.lsb_value}),
    .pop       (lsb_pop),
    .head_data (lsb_head),
    .full      (lsb_full),
    .afull     (bus.lsb_afull),
    .count     (lsb_count)
  );

  assign alu_ne = (alu_count != '0);
  assign lsb_ne = (lsb_count != '0);

`ifdef CDB_LSB_PRIO_EN
  // Fixed priority: the LSB queue wins whenever it holds an entry.
  always_comb begin
    grant_lsb = lsb_ne;
  end
`else
  cdb_src_e rr_last;

  // Round-robin: on a tie, grant the source that did not win last time.
  always_comb begin
    // NOTE: assign a default first so no path leaves the signal unassigned (no latch).
    grant_lsb = lsb_ne;
    if (alu_ne && lsb_ne) grant_lsb = (rr_last == CDB_SRC_ALU);
  end

  // Remember the last granted source; reset makes ALU win the first tie.
  always_ff @(posedge clk_in) begin
    if (clear) begin
      rr_last <= CDB_SRC_LSB;
    end else if (rdy_in && (alu_ne || lsb_ne)) begin
      rr_last <= grant_src;
    end
  end
`endif

  assign grant_src = grant_lsb ? CDB_SRC_LSB : CDB_SRC_ALU;
  assign alu_pop   = rdy_in && alu_ne && !grant_lsb;
  assign lsb_pop   = rdy_in && grant_lsb;

  // A push into a full queue that is not being popped this cycle is lost.
  assign overflow_evt = rdy_in && ((bus.alu_ready && alu_full && !alu_pop) ||
                                   (bus.lsb_ready && lsb_full && !lsb_pop));

  // Registered broadcast of the granted head plus the sticky overflow flag.
  always_ff @(posedge clk_in) begin
    if (clear) begin
      cdb_valid_q <= 1'b0;
      cdb_entry_q <= '0;
      cdb_src_q   <= CDB_SRC_ALU;
      overflow_q  <= 1'b0;
    end else if (rdy_in) begin
      if (alu_ne || lsb_ne) begin
        cdb_valid_q <= 1'b1;
        cdb_entry_q <= grant_lsb ? lsb_head : alu_head;
        cdb_src_q   <= grant_src;
      end else begin
        cdb_valid_q <= 1'b0;
      end
      if (overflow_evt) overflow_q <= 1'b1;
    end
  end

  assign bus.cdb_valid     = cdb_valid_q;
  assign bus.cdb_rob_entry = cdb_entry_q.rob_entry;
  assign bus.cdb_value     = cdb_entry_q.value;
  assign bus.cdb_src       = cdb_src_q;
  assign bus.cdb_overflow  = overflow_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus random traffic,
// all compared against a queue-based reference model of the arbitration rules.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;
  logic rob_clear_up;

  cdb_arbiter_if bus ();

  cdb_arbiter dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .rdy_in       (rdy_in),
    .rob_clear_up (rob_clear_up),
    .bus          (bus)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [ROB_W-1:0] tag;
    logic [31:0]      val;
  } ent_t;

  ent_t             q_alu [$];
  ent_t             q_lsb [$];
  bit               m_valid;
  logic [ROB_W-1:0] m_tag;
  logic [31:0]      m_val;
  bit               m_src;
  bit               m_ovf;
  bit               m_rr;    // last granted source, 1 = LSB
  int               n_cmp = 0;
  int               n_mis = 0;
  int               cyc   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  // Reference model: one clock edge of the arbitration rules.
  task automatic model_edge();
    bit   a_ne, l_ne, g_lsb;
    ent_t e;
    if (rst_in || rob_clear_up) begin
      q_alu.delete();
      q_lsb.delete();
      m_valid = 0; m_tag = '0; m_val = '0; m_src = 0; m_ovf = 0; m_rr = 1;
    end else if (rdy_in) begin
      a_ne = (q_alu.size() > 0);
      l_ne = (q_lsb.size() > 0);
`ifdef CDB_LSB_PRIO_EN
      g_lsb = l_ne;
`else
      g_lsb = (a_ne && l_ne) ? !m_rr : l_ne;
`endif
      if (a_ne || l_ne) begin
        e = g_lsb ? q_lsb.pop_front() : q_alu.pop_front();
        m_valid = 1; m_tag = e.tag; m_val = e.val; m_src = g_lsb;
        m_rr = g_lsb;
      end else begin
        m_valid = 0;
      end
      if (bus.alu_ready) begin
        if (q_alu.size() < CDB_DEPTH) q_alu.push_back('{bus.alu_rob_entry, bus.alu_value});
        else m_ovf = 1;
      end
      if (bus.lsb_ready) begin
        if (q_lsb.size() < CDB_DEPTH) q_lsb.push_back('{bus.lsb_rob_entry, bus.lsb_value});
        else m_ovf = 1;
      end
    end
  endtask

  // Advance one clock, update the model, then compare just after the edge.
  task automatic tick();
    @(posedge clk_in);
    cyc++;
    model_edge();
    #1;
    check("cdb_valid",    64'(bus.cdb_valid),     64'(m_valid));
    check("cdb_rob_entry",64'(bus.cdb_rob_entry), 64'(m_tag));
    check("cdb_value",    64'(bus.cdb_value),     64'(m_val));
    check("cdb_src",      64'(bus.cdb_src),       64'(m_src));
    check("alu_afull",    64'(bus.alu_afull),     64'(q_alu.size() >= CDB_DEPTH - 1));
    check("lsb_afull",    64'(bus.lsb_afull),     64'(q_lsb.size() >= CDB_DEPTH - 1));
    check("cdb_overflow", 64'(bus.cdb_overflow),  64'(m_ovf));
  endtask

  task automatic idle_inputs();
    bus.alu_ready = 0; bus.alu_rob_entry = '0; bus.alu_value = '0;
    bus.lsb_ready = 0; bus.lsb_rob_entry = '0; bus.lsb_value = '0;
    rob_clear_up  = 0;
  endtask

  task automatic push_both(input int i);
    bus.alu_ready = 1; bus.alu_rob_entry = ROB_W'(i);     bus.alu_value = 32'h100 + 32'(i);
    bus.lsb_ready = 1; bus.lsb_rob_entry = ROB_W'(i + 8); bus.lsb_value = 32'h200 + 32'(i);
  endtask

  initial begin
    rst_in = 1; rdy_in = 1;
    idle_inputs();
    m_valid = 0; m_tag = '0; m_val = '0; m_src = 0; m_ovf = 0; m_rr = 1;

    // Reset, then idle.
    tick(); tick();
    rst_in = 0;
    for (int i = 0; i < 5; i++) tick();

    // Single ALU push: broadcast exactly one cycle after the push edge.
    bus.alu_ready = 1; bus.alu_rob_entry = ROB_W'(3); bus.alu_value = 32'h11;
    tick();
    check("lat_not_same_cycle", 64'(bus.cdb_valid), 64'd0);
    idle_inputs();
    tick();
    check("lat_valid", 64'(bus.cdb_valid), 64'd1);
    check("lat_tag",   64'(bus.cdb_rob_entry), 64'd3);
    check("lat_value", 64'(bus.cdb_value), 64'h11);
    check("lat_src",   64'(bus.cdb_src), 64'd0);
    tick();
    check("lat_once", 64'(bus.cdb_valid), 64'd0);

    // Both producers push every cycle: alternation, fill, overflow.
    for (int i = 0; i < 8; i++) begin
      push_both(i);
      tick();
    end
    idle_inputs();
    for (int i = 0; i < 20; i++) tick();

    // Loaded LSB queue frozen by rdy_in=0: pushes ignored, state held.
    rob_clear_up = 1; tick(); rob_clear_up = 0;
    for (int i = 0; i < 3; i++) begin
      bus.lsb_ready = 1; bus.lsb_rob_entry = ROB_W'(i + 4); bus.lsb_value = 32'h300 + 32'(i);
      tick();
    end
    rdy_in = 0;
    for (int i = 0; i < 4; i++) tick();
    rdy_in = 1;
    idle_inputs();
    for (int i = 0; i < 6; i++) tick();

    // Flush with a concurrent push while both queues hold entries.
    for (int i = 0; i < 6; i++) begin
      push_both(i);
      tick();
    end
    push_both(7);
    rob_clear_up = 1;
    tick();
    check("flush_valid", 64'(bus.cdb_valid), 64'd0);
    idle_inputs();
    for (int i = 0; i < 8; i++) tick();

    // Random traffic in three load phases.
    for (int ph = 0; ph < 3; ph++) begin
      for (int i = 0; i < 600; i++) begin
        int pct;
        pct = 30 + 30 * ph;
        rdy_in        = ($urandom_range(0, 9) != 0);
        rob_clear_up  = ($urandom_range(0, 99) == 0);
        bus.alu_ready = ($urandom_range(0, 99) < pct);
        bus.lsb_ready = ($urandom_range(0, 99) < pct);
        bus.alu_rob_entry = ROB_W'($urandom);
        bus.lsb_rob_entry = ROB_W'($urandom);
        bus.alu_value     = $urandom;
        bus.lsb_value     = $urandom;
        tick();
      end
    end
    rdy_in = 1;
    idle_inputs();
    for (int i = 0; i < 10; i++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
